control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer: fetch, R-ALU, immediate, ld/st, nop and halt.
// Optional ILLEGAL_TRAP_EN: undefined opcodes raise a sticky illegal flag and halt the machine.
module control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        stop,
    input  logic        mem_done,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    localparam logic [3:0] T0   = 4'd0;
    localparam logic [3:0] T1   = 4'd1;
    localparam logic [3:0] T2   = 4'd2;
    localparam logic [3:0] T3   = 4'd3;
    localparam logic [3:0] T4   = 4'd4;
    localparam logic [3:0] T5   = 4'd5;
    localparam logic [3:0] T6   = 4'd6;
    localparam logic [3:0] T7   = 4'd7;
    localparam logic [3:0] HALT = 4'd8;

    logic [3:0] state_q, state_d;
    logic       stop_halt_q, stop_halt_d;
    logic       finish;

    logic [4:0] op;
    logic       is_ld, is_st, is_mem, is_ralu, is_imm, is_nop, is_halt;

    // Only the opcode field steers sequencing; register fields go straight to the select logic.
    logic unused_ir;
    assign unused_ir = ^IR[26:0];

    assign op      = IR[31:27];
    assign is_ld   = (op == 5'b00000);
    assign is_st   = (op == 5'b00010);
    assign is_mem  = is_ld | is_st;
    assign is_ralu = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_imm  = (op >= 5'b01100) && (op <= 5'b01110);
    assign is_nop  = (op == 5'b11010);
    assign is_halt = (op == 5'b11011);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        stop_halt_d = stop_halt_q;
        finish      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        case (state_q)
            T0: state_d = T1;
            T1: if (mem_done) state_d = T2;
            T2: begin
                if (is_mem || is_ralu || is_imm) begin
                    state_d = T3;
                end else if (is_halt) begin
                    state_d     = HALT;
                    stop_halt_d = 1'b0;
`ifdef ILLEGAL_TRAP_EN
                end else if (!is_nop) begin
                    state_d     = HALT;
                    stop_halt_d = 1'b0;
                    illegal_d   = 1'b1;
`endif
                end else begin
                    finish = 1'b1;
                end
            end
            T3: state_d = T4;
            T4: state_d = T5;
            T5: if (is_mem) state_d = T6; else finish = 1'b1;
            T6: if (is_st || mem_done) state_d = T7;
            T7: if (!is_st || mem_done) finish = 1'b1;
            HALT: begin
                // Only a stop-requested pause resumes; opcode/trap halts wait for reset.
                if (stop_halt_q && !stop) begin
                    state_d     = T0;
                    stop_halt_d = 1'b0;
                end
            end
            default: state_d = T0;
        endcase
        if (finish) begin
            state_d     = stop ? HALT : T0;
            stop_halt_d = stop;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= T0;
            stop_halt_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stop_halt_q <= stop_halt_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = 7'b0;
        {PCout, PCin, IncPC, MARin, MDRin, MDRout} = 6'b0;
        {IRin, Yin, Zin, Zlowout, Read, Write} = 6'b0;
        alu_op = 5'b0;
        run    = (state_q != HALT);
        case (state_q)
            T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
            T2: {MDRout, IRin} = 2'b11;
            T3: begin
                Grb   = is_mem | is_ralu | is_imm;
                Yin   = is_mem | is_ralu | is_imm;
                Rout  = is_ralu | is_imm;
                BAout = is_mem;
            end
            T4: begin
                if (is_ralu) begin
                    {Grc, Rout, Zin} = 3'b111;
                    alu_op = op;
                end else if (is_imm || is_mem) begin
                    {Cout, Zin} = 2'b11;
                    case (op)
                        5'b01101: alu_op = 5'b00101;
                        5'b01110: alu_op = 5'b00110;
                        default:  alu_op = 5'b00011;
                    endcase
                end
            end
            T5: begin
                Zlowout = is_mem | is_ralu | is_imm;
                Gra     = is_ralu | is_imm;
                Rin     = is_ralu | is_imm;
                MARin   = is_mem;
            end
            T6: begin
                MDRin = is_mem;
                Read  = is_ld;
                Gra   = is_st;
                Rout  = is_st;
            end
            T7: begin
                MDRout = is_ld;
                Gra    = is_ld;
                Rin    = is_ld;
                Write  = is_st;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction sequences with hand-built strobe vectors.
module tb_control_sequencer;

    logic clock = 1'b0;
    logic reset, stop, mem_done;
    logic [31:0] IR;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Read, Write;
    logic [4:0] alu_op;
    logic run, illegal;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .reset(reset), .IR(IR), .stop(stop), .mem_done(mem_done),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    logic [25:0] act;
    assign act = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin,
                  MDRout, IRin, Yin, Zin, Zlowout, Read, Write, alu_op, run, illegal};

    localparam logic [25:0] ILL   = 26'h1 << 0;
    localparam logic [25:0] RUN   = 26'h1 << 1;
    localparam logic [25:0] WRITE = 26'h1 << 7;
    localparam logic [25:0] READ  = 26'h1 << 8;
    localparam logic [25:0] ZLOW  = 26'h1 << 9;
    localparam logic [25:0] ZIN   = 26'h1 << 10;
    localparam logic [25:0] YIN   = 26'h1 << 11;
    localparam logic [25:0] IRIN  = 26'h1 << 12;
    localparam logic [25:0] MDROUT= 26'h1 << 13;
    localparam logic [25:0] MDRIN = 26'h1 << 14;
    localparam logic [25:0] MARIN = 26'h1 << 15;
    localparam logic [25:0] INCPC = 26'h1 << 16;
    localparam logic [25:0] PCIN  = 26'h1 << 17;
    localparam logic [25:0] PCOUT = 26'h1 << 18;
    localparam logic [25:0] COUT  = 26'h1 << 19;
    localparam logic [25:0] BAOUT = 26'h1 << 20;
    localparam logic [25:0] ROUT  = 26'h1 << 21;
    localparam logic [25:0] RIN   = 26'h1 << 22;
    localparam logic [25:0] GRC   = 26'h1 << 23;
    localparam logic [25:0] GRB   = 26'h1 << 24;
    localparam logic [25:0] GRA   = 26'h1 << 25;

    function automatic logic [25:0] alu(input logic [4:0] o);
        return {19'b0, o, 2'b0};
    endfunction

    localparam logic [25:0] E_T0 = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [25:0] E_T1 = ZLOW | PCIN | READ | MDRIN | RUN;
    localparam logic [25:0] E_T2 = MDROUT | IRIN | RUN;
    localparam logic [25:0] E_R3 = GRB | ROUT | YIN | RUN;
    localparam logic [25:0] E_R5 = ZLOW | GRA | RIN | RUN;
    localparam logic [25:0] E_M3 = GRB | BAOUT | YIN | RUN;
    localparam logic [25:0] E_M5 = ZLOW | MARIN | RUN;
    localparam logic [25:0] E_L6 = READ | MDRIN | RUN;
    localparam logic [25:0] E_L7 = MDROUT | GRA | RIN | RUN;
    localparam logic [25:0] E_S6 = GRA | ROUT | MDRIN | RUN;
    localparam logic [25:0] E_S7 = WRITE | RUN;
    localparam logic [25:0] E_H  = 26'h0;

    typedef struct {
        logic [25:0] exp;
        string       nm;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %07h expected %07h", e.nm, act, e.exp);
            end
        end
    end

    // Drive one cycle's inputs and queue the outputs expected during that cycle.
    task automatic cyc(input string nm, input logic [25:0] exp, input logic st,
                       input logic md, input logic rs);
        exp_t e;
        stop = st; mem_done = md; reset = rs;
        e.exp = exp; e.nm = nm;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string nm);
        cyc({nm, "_T0"}, E_T0, 1'b0, 1'b1, 1'b0);
        cyc({nm, "_T1"}, E_T1, 1'b0, 1'b1, 1'b0);
        cyc({nm, "_T2"}, E_T2, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stop = 1'b0; mem_done = 1'b0; IR = 32'h19890000;
        @(posedge clock); #1;

        // add R3,R1,R2 with mem_done held high
        fetch("add");
        cyc("add_T3", E_R3, 1'b0, 1'b1, 1'b0);
        cyc("add_T4", GRC | ROUT | ZIN | alu(5'b00011) | RUN, 1'b0, 1'b1, 1'b0);
        cyc("add_T5", E_R5, 1'b0, 1'b1, 1'b0);

        // ld R1,0x10(R2) with a 3-cycle memory stall in T6
        IR = 32'h00900010;
        fetch("ld");
        cyc("ld_T3", E_M3, 1'b0, 1'b0, 1'b0);
        cyc("ld_T4", COUT | ZIN | alu(5'b00011) | RUN, 1'b0, 1'b0, 1'b0);
        cyc("ld_T5", E_M5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("ld_T6_wait", E_L6, 1'b0, 1'b0, 1'b0);
        cyc("ld_T6_done", E_L6, 1'b0, 1'b1, 1'b0);
        cyc("ld_T7", E_L7, 1'b0, 1'b0, 1'b0);

        // add with stop raised during T4: completes, pauses, resumes on stop=0
        IR = 32'h19890000;
        fetch("stp");
        cyc("stp_T3", E_R3, 1'b0, 1'b1, 1'b0);
        cyc("stp_T4", GRC | ROUT | ZIN | alu(5'b00011) | RUN, 1'b1, 1'b1, 1'b0);
        cyc("stp_T5", E_R5, 1'b1, 1'b1, 1'b0);
        cyc("stp_H1", E_H, 1'b1, 1'b1, 1'b0);
        cyc("stp_H2", E_H, 1'b0, 1'b1, 1'b0);

        // andi and ori immediates, plus a different R-ALU op (resumed from stop-halt into T0)
        IR = 32'h68000000;
        fetch("andi");
        cyc("andi_T3", E_R3, 1'b0, 1'b0, 1'b0);
        cyc("andi_T4", COUT | ZIN | alu(5'b00101) | RUN, 1'b0, 1'b0, 1'b0);
        cyc("andi_T5", E_R5, 1'b0, 1'b0, 1'b0);
        IR = 32'h70000000;
        fetch("ori");
        cyc("ori_T3", E_R3, 1'b0, 1'b0, 1'b0);
        cyc("ori_T4", COUT | ZIN | alu(5'b00110) | RUN, 1'b0, 1'b0, 1'b0);
        cyc("ori_T5", E_R5, 1'b0, 1'b0, 1'b0);
        IR = 32'h58000000;
        fetch("r11");
        cyc("r11_T3", E_R3, 1'b0, 1'b0, 1'b0);
        cyc("r11_T4", GRC | ROUT | ZIN | alu(5'b01011) | RUN, 1'b0, 1'b0, 1'b0);
        cyc("r11_T5", E_R5, 1'b0, 1'b0, 1'b0);

        // nop returns to T0, then nop with stop at its last state pauses
        IR = 32'hD0000000;
        fetch("nop");
        cyc("nop_T0", E_T0, 1'b0, 1'b1, 1'b0);
        cyc("nops_T1", E_T1, 1'b0, 1'b1, 1'b0);
        cyc("nops_T2", E_T2, 1'b1, 1'b1, 1'b0);
        cyc("nops_H", E_H, 1'b0, 1'b0, 1'b0);

        // halt opcode: stop toggling must not release it, reset does
        IR = 32'hD8000000;
        fetch("hlt");
        for (int i = 0; i < 20; i++) cyc("hlt_H", E_H, 1'(i % 2), 1'b1, 1'b0);
        cyc("hlt_rst", E_H, 1'b1, 1'b1, 1'b1);

        // undefined opcode
        IR = 32'hF8000000;
        fetch("und");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) cyc("und_H", E_H | ILL, 1'(i % 2), 1'b0, 1'b0);
        cyc("und_rst", E_H | ILL, 1'b0, 1'b0, 1'b1);
`endif

        // st with T1 stall, then reset during T7 write wait
        IR = 32'h10900010;
        cyc("st_T0", E_T0, 1'b0, 1'b0, 1'b0);
        cyc("st_T1_wait", E_T1, 1'b0, 1'b0, 1'b0);
        cyc("st_T1_done", E_T1, 1'b0, 1'b1, 1'b0);
        cyc("st_T2", E_T2, 1'b0, 1'b0, 1'b0);
        cyc("st_T3", E_M3, 1'b0, 1'b0, 1'b0);
        cyc("st_T4", COUT | ZIN | alu(5'b00011) | RUN, 1'b0, 1'b0, 1'b0);
        cyc("st_T5", E_M5, 1'b0, 1'b0, 1'b0);
        cyc("st_T6", E_S6, 1'b0, 1'b0, 1'b0);
        cyc("st_T7_wait", E_S7, 1'b0, 1'b0, 1'b0);
        cyc("st_T7_rst", E_S7, 1'b1, 1'b1, 1'b1);
        cyc("st_after_rst", E_T0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
